// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RISC-V load/store funct3 encodings and bus widths.
package riscv_mem_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int FUNCT3_W = 3;
  localparam int BYTES_W  = DATA_W / 8;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the control unit (master) and
// the data-memory responder (slave).
interface data_mem_responder_if;
  import riscv_mem_pkg::*;

  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [FUNCT3_W-1:0] funct3;
  logic [DATA_W-1:0]   rdata;
  logic                stall;
  logic                done;
  logic                misalign;

  modport master (
    output mem_read, mem_write, addr, wdata, funct3,
    input  rdata, stall, done, misalign
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata, funct3,
    output rdata, stall, done, misalign
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
// Only present when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]          i_byteOff,
  input  logic [FUNCT3_W-1:0] i_funct3,
  input  logic                i_isWrite,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rword,
  output logic [BYTES_W-1:0]  o_wmask,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_byteOff, 3'b000} +: 8];
  assign w_half = i_byteOff[1] ? i_rword[31:16] : i_rword[15:0];

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    o_wmask    = '0;
    o_wdata    = i_wdata;
    o_rdata    = i_rword;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_wmask = 4'b0001 << i_byteOff;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_wmask    = i_byteOff[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_half[15]}}, w_half};
        o_misalign = i_byteOff[0];
      end
      F3_W: begin
        o_wmask    = 4'b1111;
        o_misalign = |i_byteOff;
      end
      F3_BU: begin
        o_rdata    = {24'd0, w_byte};
        o_misalign = i_isWrite;
      end
      F3_HU: begin
        o_rdata    = {16'd0, w_half};
        o_misalign = i_isWrite | i_byteOff[0];
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule
`endif

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave for LW/SW with LATENCY wait states and stall.
// Define MEM_SUBWORD_EN for byte/halfword accesses selected by funct3.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LO_W  = IDX_W + 2;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t              r_state, w_nextState;
  logic [CNT_W-1:0]    r_cnt, w_nextCnt;
  logic                w_stall;
  logic [LO_W-1:0]     r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [FUNCT3_W-1:0] r_funct3, w_funct3;
  logic                r_isWrite, w_isWrite;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_misalign;
  logic                w_req, w_accept, w_enterDone, w_commit, w_misalign;
  logic [BYTES_W-1:0]  w_wmask;
  logic [DATA_W-1:0]   w_wdataLane, w_rword, w_loadData;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_unused;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_accept = (r_state == S_IDLE) && w_req;

  // The live request is used in IDLE so a zero-latency access completes on its accept edge.
  assign w_addr    = (r_state == S_IDLE) ? bus.addr[LO_W-1:0] : r_addr;
  assign w_wdata   = (r_state == S_IDLE) ? bus.wdata          : r_wdata;
  assign w_funct3  = (r_state == S_IDLE) ? bus.funct3         : r_funct3;
  assign w_isWrite = (r_state == S_IDLE) ? bus.mem_write      : r_isWrite;
  assign w_idx     = w_addr[LO_W-1:2];
  assign w_rword   = r_mem[w_idx];

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          if (LATENCY == 0) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = LAT_CNT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_nextState = S_DONE;
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_enterDone = (w_nextState == S_DONE) && (r_state != S_DONE);
  assign w_commit    = w_enterDone && w_isWrite && !w_misalign && rst_n;

`ifdef MEM_SUBWORD_EN
  mem_lane_align u_align (
    .i_byteOff  (w_addr[1:0]),
    .i_funct3   (w_funct3),
    .i_isWrite  (w_isWrite),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdataLane),
    .o_rdata    (w_loadData),
    .o_misalign (w_misalign)
  );
  assign w_unused = ^bus.addr[ADDR_W-1:LO_W];
`else
  assign w_wmask     = '1;
  assign w_wdataLane = w_wdata;
  assign w_loadData  = w_rword;
  assign w_misalign  = |w_addr[1:0];
  assign w_unused    = ^{bus.addr[ADDR_W-1:LO_W], w_funct3};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_isWrite  <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_accept) begin
        r_addr    <= bus.addr[LO_W-1:0];
        r_wdata   <= bus.wdata;
        r_funct3  <= bus.funct3;
        r_isWrite <= bus.mem_write;
      end
      if (w_enterDone) begin
        r_rdata    <= (w_isWrite || w_misalign) ? '0 : w_loadData;
        r_misalign <= w_misalign;
      end else begin
        r_rdata    <= '0;
        r_misalign <= 1'b0;
      end
    end
  end

  // The array has no reset; a store lands only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < BYTES_W; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdataLane[8*b +: 8];
      end
    end
  end

  assign bus.stall    = w_stall & rst_n;
  assign bus.done     = (r_state == S_DONE);
  assign bus.rdata    = r_rdata;
  assign bus.misalign = r_misalign;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a LATENCY=2 and a LATENCY=0 responder against a
// byte-addressed reference memory, plus directed reset corner cases.
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        expMis;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    bit          gotDone;
    int          doneCycle;
    int          stallCycles;
    bit          stallAtDone;
    logic [31:0] rdata;
    bit          mis;
    bit          postDone;
    bit          postMis;
    bit          postStall;
    logic [31:0] postRdata;
  } result_t;

  logic clk;
  logic rstA_n;
  logic rstB_n;
  int   checks;
  int   errors;

  logic [7:0] refMem [2][1024];
  bit         refOk  [2][1024];
  logic [2:0] f3Choices [8] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011, 3'b110, 3'b111};

  data_mem_responder_if busA ();
  data_mem_responder_if busB ();

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dutA (
    .clk   (clk),
    .rst_n (rstA_n),
    .bus   (busA.slave)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dutB (
    .clk   (clk),
    .rst_n (rstB_n),
    .bus   (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed view of memory: 1024 bytes, little-endian, addresses wrap mod 1024.
  function automatic void refAccess(input bit sel, input bit isWr, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [2:0] f3,
                                    output bit mis, output logic [31:0] rd, output bit known);
    int     size;
    bit     sgn;
    bit     ok;
    int     base;
    longint v;
    size = 4;
    sgn  = 1'b0;
    ok   = 1'b1;
`ifdef MEM_SUBWORD_EN
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: size = 4;
      3'b100: begin size = 1; ok = !isWr; end
      3'b101: begin size = 2; ok = !isWr; end
      default: ok = 1'b0;
    endcase
`else
    if (f3 === 3'bxxx) ok = 1'b1;
`endif
    mis   = !ok || ((int'(addr[1:0]) % size) != 0);
    rd    = 32'd0;
    known = 1'b1;
    if (mis) return;
    base = int'(addr[9:0]);
    if (isWr) begin
      for (int b = 0; b < size; b++) begin
        refMem[sel][base+b] = wd[8*b +: 8];
        refOk[sel][base+b]  = 1'b1;
      end
    end else begin
      v = 0;
      for (int b = 0; b < size; b++) begin
        v     = v | (longint'(refMem[sel][base+b]) << (8*b));
        known = known && refOk[sel][base+b];
      end
      if (sgn && v >= (longint'(1) << (8*size-1))) v = v - (longint'(1) << (8*size));
      rd = v[31:0];
    end
  endfunction

  function automatic logic getDone(input bit sel);
    return sel ? busB.done : busA.done;
  endfunction

  function automatic logic getStall(input bit sel);
    return sel ? busB.stall : busA.stall;
  endfunction

  function automatic logic getMis(input bit sel);
    return sel ? busB.misalign : busA.misalign;
  endfunction

  function automatic logic [31:0] getRdata(input bit sel);
    return sel ? busB.rdata : busA.rdata;
  endfunction

  task automatic driveReq(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
    if (sel) begin
      busB.mem_read = rd; busB.mem_write = wr; busB.addr = a; busB.wdata = d; busB.funct3 = f;
    end else begin
      busA.mem_read = rd; busA.mem_write = wr; busA.addr = a; busA.wdata = d; busA.funct3 = f;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; request is held until done is seen, then dropped.
  task automatic applyStimulus(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f, output result_t r);
    r.gotDone = 0; r.doneCycle = -1; r.stallCycles = 0; r.stallAtDone = 0;
    r.rdata = 32'hFFFF_FFFF; r.mis = 0;
    driveReq(sel, rd, wr, a, d, f);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (getDone(sel)) begin
        r.gotDone     = 1;
        r.doneCycle   = c;
        r.stallAtDone = getStall(sel);
        r.rdata       = getRdata(sel);
        r.mis         = getMis(sel);
        break;
      end
      if (getStall(sel)) r.stallCycles++;
      @(posedge clk);
      #1;
    end
    driveReq(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    r.postDone  = getDone(sel);
    r.postMis   = getMis(sel);
    r.postStall = getStall(sel);
    r.postRdata = getRdata(sel);
    @(posedge clk);
    #1;
  endtask

  task automatic runAccess(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f, output result_t r,
                           output bit mis, output logic [31:0] rdExp, output bit known);
    refAccess(sel, wr, a, d, f, mis, rdExp, known);
    applyStimulus(sel, rd, wr, a, d, f, r);
  endtask

  task automatic checkAccess(input string name, input bit sel, input result_t r,
                             input bit expMis, input logic [31:0] expRd, input bit checkRd);
    int lat;
    lat = sel ? 0 : 2;
    checkOutput({name, " done"}, 32'(r.gotDone), 32'd1);
    checkOutput({name, " doneCycle"}, 32'(r.doneCycle), 32'(lat + 1));
    checkOutput({name, " stallCycles"}, 32'(r.stallCycles), 32'(lat + 1));
    checkOutput({name, " stallAtDone"}, 32'(r.stallAtDone), 32'd0);
    checkOutput({name, " misalign"}, 32'(r.mis), 32'(expMis));
    if (checkRd) checkOutput({name, " rdata"}, r.rdata, expRd);
    checkOutput({name, " postFlags"}, {29'd0, r.postDone, r.postMis, r.postStall}, 32'd0);
    checkOutput({name, " postRdata"}, r.postRdata, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    result_t     r;
    bit          mis;
    bit          known;
    bit          sel;
    logic [31:0] rdExp;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    int          op;

    checks = 0;
    errors = 0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) refOk[s][i] = 1'b0;

    vecs.push_back('{0, 1, 32'h10,  32'hDEADBEEF, F3_W, 0, 32'h0});
    vecs.push_back('{1, 0, 32'h10,  32'h0,        F3_W, 0, 32'hDEADBEEF});
    vecs.push_back('{1, 0, 32'h12,  32'h0,        F3_W, 1, 32'h0});
    vecs.push_back('{0, 1, 32'h13,  32'h55,       F3_W, 1, 32'h0});
    vecs.push_back('{1, 0, 32'h10,  32'h0,        F3_W, 0, 32'hDEADBEEF});
    vecs.push_back('{0, 1, 32'h400, 32'hCAFE0001, F3_W, 0, 32'h0});
    vecs.push_back('{1, 0, 32'h0,   32'h0,        F3_W, 0, 32'hCAFE0001});
    vecs.push_back('{1, 1, 32'h30,  32'h77,       F3_W, 0, 32'h0});
    vecs.push_back('{1, 0, 32'h30,  32'h0,        F3_W, 0, 32'h77});
`ifdef MEM_SUBWORD_EN
    vecs.push_back('{0, 1, 32'h80,  32'h000000F0, F3_W,  0, 32'h0});
    vecs.push_back('{1, 0, 32'h80,  32'h0,        F3_B,  0, 32'hFFFFFFF0});
    vecs.push_back('{1, 0, 32'h80,  32'h0,        F3_BU, 0, 32'h000000F0});
    vecs.push_back('{0, 1, 32'h81,  32'hAA,       F3_B,  0, 32'h0});
    vecs.push_back('{1, 0, 32'h80,  32'h0,        F3_W,  0, 32'h0000AAF0});
    vecs.push_back('{1, 0, 32'h81,  32'h0,        F3_H,  1, 32'h0});
`endif

    rstA_n = 1'b1;
    rstB_n = 1'b1;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #2;
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    busA.mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset A stall", 32'(busA.stall), 32'd0);
    checkOutput("reset A done", 32'(busA.done), 32'd0);
    checkOutput("reset A rdata", busA.rdata, 32'd0);
    checkOutput("reset A misalign", 32'(busA.misalign), 32'd0);
    checkOutput("reset B done/stall", {30'd0, busB.done, busB.stall}, 32'd0);
    busA.mem_read = 1'b0;
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      runAccess(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, r, mis, rdExp, known);
      checkAccess($sformatf("vec%0d", i), 0, r, vecs[i].expMis, vecs[i].expRdata, 1'b1);
    end

    // Reset during WAIT must drop the pending store and clear stall/done at once.
    runAccess(0, 0, 1, 32'h20, 32'h11111111, F3_W, r, mis, rdExp, known);
    checkAccess("rstA prime", 0, r, 1'b0, 32'h0, 1'b1);
    driveReq(0, 1'b0, 1'b1, 32'h20, 32'h1234, F3_W);
    @(negedge clk);
    checkOutput("rstA accept stall", 32'(busA.stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstA wait stall", 32'(busA.stall), 32'd1);
    rstA_n = 1'b0;
    #1;
    checkOutput("rstA stall", 32'(busA.stall), 32'd0);
    checkOutput("rstA done", 32'(busA.done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    rstA_n = 1'b1;
    @(posedge clk);
    #1;
    runAccess(0, 1, 0, 32'h20, 32'h0, F3_W, r, mis, rdExp, known);
    checkAccess("rstA reload", 0, r, 1'b0, 32'h11111111, 1'b1);

    // Zero-latency instance: one stall cycle, and reset in the accept cycle blocks the store.
    runAccess(1, 0, 1, 32'h40, 32'hA5A5A5A5, F3_W, r, mis, rdExp, known);
    checkAccess("lat0 store", 1, r, 1'b0, 32'h0, 1'b1);
    runAccess(1, 1, 0, 32'h40, 32'h0, F3_W, r, mis, rdExp, known);
    checkAccess("lat0 load", 1, r, 1'b0, 32'hA5A5A5A5, 1'b1);
    driveReq(1, 1'b0, 1'b1, 32'h40, 32'h1, F3_W);
    @(negedge clk);
    checkOutput("rstB accept stall", 32'(busB.stall), 32'd1);
    rstB_n = 1'b0;
    #1;
    checkOutput("rstB stall", 32'(busB.stall), 32'd0);
    checkOutput("rstB done", 32'(busB.done), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rstB_n = 1'b1;
    @(posedge clk);
    #1;
    runAccess(1, 1, 0, 32'h40, 32'h0, F3_W, r, mis, rdExp, known);
    checkAccess("rstB reload", 1, r, 1'b0, 32'hA5A5A5A5, 1'b1);

    for (int n = 0; n < 160; n++) begin
      sel = ($urandom_range(0, 3) == 0);
      op  = $urandom_range(0, 2);
      a   = $urandom;
      a[9:2] = 8'($urandom_range(0, 31));
`ifdef MEM_SUBWORD_EN
      f = f3Choices[$urandom_range(0, 7)];
`else
      f = f3Choices[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
      d = $urandom;
      runAccess(sel, (op != 1), (op != 0), a, d, f, r, mis, rdExp, known);
      checkAccess($sformatf("rand%0d", n), sel, r, mis, rdExp, known);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
